ext_pipe: RTL and testbench

Parametrised, pipelined immediate extender for the decode stage. It accepts one immediate per cycle with a tag on a valid/ready handshake and extends it to `DATA_W` bits in one of four modes. Output is registered behind a 2-entry skid buffer, so the execute stage can stall without losing data. Illegal mode codes are flagged and counted.

---
 rtl/ext_pkg.sv | 17 +
 rtl/ext_core.sv | 42 ++++
 rtl/ext_pipe.sv | 142 ++++++++++++++
 tb/tb_ext_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// Shared definitions for the decode-stage immediate extender.
// Mode encodings and the 3-bit mode type used by ext_core and ext_pipe.
package ext_pkg;

    typedef logic [2:0] ext_op_t;

    localparam ext_op_t EXT_ZERO   = 3'b000;
    localparam ext_op_t EXT_UPPER  = 3'b001;
    localparam ext_op_t EXT_SIGN   = 3'b010;
    localparam ext_op_t EXT_BRANCH = 3'b011;

    // Any code with the top bit set is reserved.
    function automatic logic ext_op_illegal(input ext_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extension: zero, upper, sign and branch modes.
// Illegal mode codes produce a zero value with err set.
module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [IMM_W-1:0]  imm,
    input  ext_op_t           op,
    output logic [DATA_W-1:0] value,
    output logic              err
);

    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] sext;

    always_comb begin
        zext              = '0;
        zext[IMM_W-1:0]   = imm;
        sext              = {DATA_W{imm[IMM_W-1]}};
        sext[IMM_W-1:0]   = imm;
    end

    always_comb begin
        value = '0;
        err   = 1'b0;
        if (ext_op_illegal(op)) begin
            err = 1'b1;
        end else begin
            case (op)
                EXT_ZERO:   value = zext;
                EXT_UPPER:  value = zext << (DATA_W - IMM_W);
                EXT_SIGN:   value = sext;
                EXT_BRANCH: value = sext << BR_SHIFT;
                default:    value = '0;
            endcase
        end
    end

endmodule

// File: rtl/ext_pipe.sv
// Pipelined immediate extender: ext_core feeding a main output register
// backed by a one-entry skid register, plus a saturating illegal-op counter.
module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W    = 16,
    parameter int DATA_W   = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [2:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
);

    logic [DATA_W-1:0] ext_value;
    logic              ext_err;

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_imm_q,   main_imm_d;
    logic [TAG_W-1:0]  main_tag_q,   main_tag_d;
    logic              main_err_q,   main_err_d;

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_imm_q,   skid_imm_d;
    logic [TAG_W-1:0]  skid_tag_q,   skid_tag_d;
    logic              skid_err_q,   skid_err_d;

    logic [CNT_W-1:0]  err_cnt_q,    err_cnt_d;

    logic              accept;
    logic              pop;

    ext_core #(
        .IMM_W    (IMM_W),
        .DATA_W   (DATA_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .imm   (in_imm),
        .op    (in_op),
        .value (ext_value),
        .err   (ext_err)
    );

    // in_ready depends only on registered state, never on out_ready.
    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign pop      = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_err_d   = skid_err_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            // An accept implies the skid is empty, so the skid-drain and accept paths never overlap.
            if (pop) begin
                if (skid_valid_q) begin
                    main_valid_d = 1'b1;
                    main_imm_d   = skid_imm_q;
                    main_tag_d   = skid_tag_q;
                    main_err_d   = skid_err_q;
                    skid_valid_d = 1'b0;
                end else if (!accept) begin
                    main_valid_d = 1'b0;
                end
            end

            if (accept) begin
                if (!main_valid_q || out_ready) begin
                    main_valid_d = 1'b1;
                    main_imm_d   = ext_value;
                    main_tag_d   = in_tag;
                    main_err_d   = ext_err;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_imm_d   = ext_value;
                    skid_tag_d   = in_tag;
                    skid_err_d   = ext_err;
                end
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (!flush && accept && ext_err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_err_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_err_q   <= skid_err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_imm   = main_imm_q;
    assign out_tag   = main_tag_q;
    assign out_err   = main_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: default instance, a 2-bit counter instance
// and a 24-bit/shift-4 instance, all driven by the same input stimulus.
module tb_ext_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_imm;
    logic [2:0]  in_op;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_err_a;
    logic [31:0] out_imm_a;
    logic [4:0]  out_tag_a;
    logic [7:0]  err_cnt_a;

    logic        in_ready_b, out_valid_b, out_err_b;
    logic [31:0] out_imm_b;
    logic [4:0]  out_tag_b;
    logic [1:0]  err_cnt_b;

    logic        in_ready_c, out_valid_c, out_err_c;
    logic [23:0] out_imm_c;
    logic [4:0]  out_tag_c;
    logic [7:0]  err_cnt_c;

    int vectors;
    int miscompares;

    ext_pipe dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a), .out_tag(out_tag_a),
        .out_err(out_err_a), .err_cnt(err_cnt_a)
    );

    ext_pipe #(.CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b), .out_tag(out_tag_b),
        .out_err(out_err_b), .err_cnt(err_cnt_b)
    );

    ext_pipe #(.DATA_W(24), .BR_SHIFT(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_imm(out_imm_c), .out_tag(out_tag_c),
        .out_err(out_err_c), .err_cnt(err_cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] imm,
                                 input logic [2:0] op, input logic [4:0] tag);
        in_valid = valid;
        in_imm   = imm;
        in_op    = op;
        in_tag   = tag;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b1;
        applyStimulus(1'b0, 16'h0000, 3'b000, 5'd0);

        #12;
        checkOutput("rst_out_valid", {31'b0, out_valid_a}, 32'd0);
        checkOutput("rst_out_imm",   out_imm_a,            32'd0);
        checkOutput("rst_out_tag",   {27'b0, out_tag_a},   32'd0);
        checkOutput("rst_out_err",   {31'b0, out_err_a},   32'd0);
        checkOutput("rst_err_cnt",   {24'b0, err_cnt_a},   32'd0);
        checkOutput("rst_in_ready",  {31'b0, in_ready_a},  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] back-to-back extension modes");
        applyStimulus(1'b1, 16'hFFFF, 3'b000, 5'd1);
        tick();
        checkOutput("zero_valid", {31'b0, out_valid_a}, 32'd1);
        checkOutput("zero_imm",   out_imm_a,            32'h0000FFFF);
        checkOutput("zero_tag",   {27'b0, out_tag_a},   32'd1);
        applyStimulus(1'b1, 16'h1234, 3'b001, 5'd2);
        tick();
        checkOutput("upper_imm",  out_imm_a,            32'h12340000);
        checkOutput("upper_tag",  {27'b0, out_tag_a},   32'd2);
        applyStimulus(1'b1, 16'h8001, 3'b010, 5'd3);
        tick();
        checkOutput("sign_imm",   out_imm_a,            32'hFFFF8001);
        checkOutput("sign_err",   {31'b0, out_err_a},   32'd0);
        applyStimulus(1'b1, 16'h8000, 3'b011, 5'd4);
        tick();
        checkOutput("branch_imm", out_imm_a,            32'hFFFE0000);
        checkOutput("branch_tag", {27'b0, out_tag_a},   32'd4);
        applyStimulus(1'b0, 16'h0000, 3'b000, 5'd0);
        tick();
        checkOutput("drain_valid", {31'b0, out_valid_a}, 32'd0);

        $display("[TB] illegal ops");
        applyStimulus(1'b1, 16'h1234, 3'b101, 5'd7);
        tick();
        checkOutput("ill1_imm", out_imm_a,            32'd0);
        checkOutput("ill1_err", {31'b0, out_err_a},   32'd1);
        checkOutput("ill1_cnt", {24'b0, err_cnt_a},   32'd1);
        applyStimulus(1'b1, 16'hABCD, 3'b111, 5'd8);
        tick();
        checkOutput("ill2_imm", out_imm_a,            32'd0);
        checkOutput("ill2_err", {31'b0, out_err_a},   32'd1);
        checkOutput("ill2_cnt", {24'b0, err_cnt_a},   32'd2);
        applyStimulus(1'b0, 16'h0000, 3'b000, 5'd0);
        tick();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h0011, 3'b000, 5'd1);
        tick();
        checkOutput("bp_main_tag1", {27'b0, out_tag_a},  32'd1);
        checkOutput("bp_ready_1",   {31'b0, in_ready_a}, 32'd1);
        applyStimulus(1'b1, 16'h0022, 3'b000, 5'd2);
        tick();
        checkOutput("bp_ready_0",   {31'b0, in_ready_a}, 32'd0);
        checkOutput("bp_hold_tag",  {27'b0, out_tag_a},  32'd1);
        applyStimulus(1'b1, 16'h0033, 3'b000, 5'd3);
        tick();
        checkOutput("bp_stall_tag", {27'b0, out_tag_a},  32'd1);
        checkOutput("bp_stall_imm", out_imm_a,           32'h00000011);
        checkOutput("bp_stall_rdy", {31'b0, in_ready_a}, 32'd0);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_out2_tag",  {27'b0, out_tag_a},  32'd2);
        checkOutput("bp_out2_imm",  out_imm_a,           32'h00000022);
        checkOutput("bp_out2_rdy",  {31'b0, in_ready_a}, 32'd1);
        tick();
        checkOutput("bp_out3_tag",  {27'b0, out_tag_a},  32'd3);
        checkOutput("bp_out3_imm",  out_imm_a,           32'h00000033);
        applyStimulus(1'b0, 16'h0000, 3'b000, 5'd0);
        tick();
        checkOutput("bp_empty",     {31'b0, out_valid_a}, 32'd0);

        $display("[TB] flush");
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h0044, 3'b000, 5'd4);
        tick();
        applyStimulus(1'b1, 16'h0055, 3'b000, 5'd5);
        tick();
        checkOutput("fl_skid_full", {31'b0, in_ready_a}, 32'd0);
        flush = 1'b1;
        applyStimulus(1'b1, 16'h0066, 3'b110, 5'd6);
        tick();
        checkOutput("fl_valid",  {31'b0, out_valid_a}, 32'd0);
        checkOutput("fl_ready",  {31'b0, in_ready_a},  32'd1);
        checkOutput("fl_cnt",    {24'b0, err_cnt_a},   32'd2);
        tick();
        checkOutput("fl_prio_valid", {31'b0, out_valid_a}, 32'd0);
        checkOutput("fl_prio_cnt",   {24'b0, err_cnt_a},   32'd2);
        flush = 1'b0;
        applyStimulus(1'b0, 16'h0000, 3'b000, 5'd0);
        out_ready = 1'b1;
        tick();
        checkOutput("fl_after_valid", {31'b0, out_valid_a}, 32'd0);

        $display("[TB] counter saturation");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 16'h0F0F, 3'b100, 5'(i));
            tick();
        end
        checkOutput("sat_cnt8", {24'b0, err_cnt_a}, 32'd6);
        checkOutput("sat_cnt2", {30'b0, err_cnt_b}, 32'd3);
        applyStimulus(1'b0, 16'h0000, 3'b000, 5'd0);
        tick();

        $display("[TB] asynchronous reset mid-stream");
        out_ready = 1'b0;
        applyStimulus(1'b1, 16'h0100, 3'b000, 5'd8);
        tick();
        applyStimulus(1'b1, 16'h0200, 3'b000, 5'd9);
        tick();
        checkOutput("ar_skid_full", {31'b0, in_ready_a}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_valid", {31'b0, out_valid_a}, 32'd0);
        checkOutput("ar_imm",   out_imm_a,            32'd0);
        checkOutput("ar_tag",   {27'b0, out_tag_a},   32'd0);
        checkOutput("ar_err",   {31'b0, out_err_a},   32'd0);
        checkOutput("ar_cnt",   {24'b0, err_cnt_a},   32'd0);
        checkOutput("ar_ready", {31'b0, in_ready_a},  32'd1);
        out_ready = 1'b1;
        applyStimulus(1'b1, 16'h7FFF, 3'b010, 5'd3);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkOutput("ar_first_valid", {31'b0, out_valid_a}, 32'd1);
        checkOutput("ar_first_imm",   out_imm_a,            32'h00007FFF);

        $display("[TB] 24-bit branch with shift 4");
        applyStimulus(1'b1, 16'h8000, 3'b011, 5'd10);
        tick();
        checkOutput("br24_imm",  {8'b0, out_imm_c}, 32'h00F80000);
        checkOutput("br32_imm",  out_imm_a,         32'hFFFE0000);
        applyStimulus(1'b0, 16'h0000, 3'b000, 5'd0);
        tick();

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
